// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and ALU select codes for the
// accumulator CPU control unit.
package cpu_ctrl_pkg;

    localparam logic [2:0] OP_LDA  = 3'b000;
    localparam logic [2:0] OP_STA  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_HLT  = 3'b101;
    localparam logic [2:0] OP_MVA  = 3'b110;
    localparam logic [2:0] OP_ADDA = 3'b111;

    localparam logic [1:0] ALU_PASS_A = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_PASS_B = 2'b11;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_EXEC2,
        S_MEM,
        S_HALT
    } state_t;

    function automatic int wait_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory request cycles without mem_ready and flags the cycle
// in which the WAIT_LIMIT-th unanswered request cycle occurs.
module mem_wait_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    localparam int W = wait_w(WAIT_LIMIT);
    localparam logic [W-1:0] LAST = W'(WAIT_LIMIT - 1);

    logic [W-1:0] count;

    assign timeout = req && !ready && (count == LAST);

    // Any non-request cycle or completed transfer means a state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!req || ready || timeout) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute control unit for the accumulator CPU.
// Define CTRL_ACII_EN to enable the MVA/ADDA (ACII register) opcodes.
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] op_code,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_on_adr,
    output logic       pc_on_adr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       clr_pc,
    output logic       ld_acii,
    output logic       source_ac,
    output logic [1:0] pass_add,
    output logic       sel_acii,
    output logic       sel_ir,
    output logic       sel_zero,
    output logic       halted,
    output logic       bus_err,
    output logic       illegal_op
);

    state_t state;
    logic   timeout;

    mem_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .req    (mem_rd | mem_wr),
        .ready  (mem_ready),
        .timeout(timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RESET;
            bus_err <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (timeout) begin
                        state   <= S_HALT;
                        bus_err <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (op_code == OP_LDA || op_code == OP_STA) begin
                        state <= S_MEM;
                    end else if (op_code == OP_HLT) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC:  state <= (op_code == OP_JMP) ? S_EXEC2 : S_FETCH;
                S_EXEC2: state <= S_FETCH;
                S_MEM: begin
                    if (mem_ready) begin
                        state <= S_FETCH;
                    end else if (timeout) begin
                        state   <= S_HALT;
                        bus_err <= 1'b1;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_on_adr  = 1'b0;
        pc_on_adr  = 1'b0;
        ld_ir      = 1'b0;
        ld_ac      = 1'b0;
        ld_pc      = 1'b0;
        inc_pc     = 1'b0;
        clr_pc     = 1'b0;
        ld_acii    = 1'b0;
        source_ac  = 1'b0;
        pass_add   = ALU_PASS_A;
        sel_acii   = 1'b0;
        sel_ir     = 1'b0;
        sel_zero   = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        unique case (state)
            S_RESET: clr_pc = 1'b1;
            S_FETCH: begin
                pc_on_adr = 1'b1;
                mem_rd    = 1'b1;
                ld_ir     = mem_ready;
            end
            S_DECODE: inc_pc = 1'b1;
            S_MEM: begin
                ir_on_adr = 1'b1;
                if (op_code == OP_STA) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                    ld_ac  = mem_ready;
                end
            end
            S_EXEC: begin
                case (op_code)
                    OP_ADDI: begin
                        sel_ir    = 1'b1;
                        pass_add  = ALU_ADD;
                        ld_ac     = 1'b1;
                        source_ac = 1'b1;
                    end
                    OP_CLR: begin
                        sel_zero  = 1'b1;
                        pass_add  = ALU_PASS_B;
                        ld_ac     = 1'b1;
                        source_ac = 1'b1;
                    end
                    OP_JMP: begin
                        sel_ir   = 1'b1;
                        pass_add = ALU_PASS_B;
                        ld_acii  = 1'b1;
                    end
`ifdef CTRL_ACII_EN
                    OP_MVA: ld_acii = 1'b1;
                    OP_ADDA: begin
                        sel_acii  = 1'b1;
                        pass_add  = ALU_ADD;
                        ld_ac     = 1'b1;
                        source_ac = 1'b1;
                    end
`else
                    OP_MVA, OP_ADDA: illegal_op = 1'b1;
`endif
                    default: ;
                endcase
            end
            S_EXEC2: ld_pc = 1'b1;
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench: a per-instruction cycle model queues the expected
// strobe vector for every cycle and a monitor compares on the falling edge.
module tb_cpu_controller;

    localparam int LIMIT = 15;

    localparam logic [2:0] LDA  = 3'd0;
    localparam logic [2:0] STA  = 3'd1;
    localparam logic [2:0] ADDI = 3'd2;
    localparam logic [2:0] CLR  = 3'd3;
    localparam logic [2:0] JMP  = 3'd4;
    localparam logic [2:0] HLT  = 3'd5;
    localparam logic [2:0] MVA  = 3'd6;
    localparam logic [2:0] ADDA = 3'd7;

    typedef logic [18:0] vec_t;

    localparam vec_t V_RD   = vec_t'(1) << 18;
    localparam vec_t V_WR   = vec_t'(1) << 17;
    localparam vec_t V_IRA  = vec_t'(1) << 16;
    localparam vec_t V_PCA  = vec_t'(1) << 15;
    localparam vec_t V_LDIR = vec_t'(1) << 14;
    localparam vec_t V_LDAC = vec_t'(1) << 13;
    localparam vec_t V_LDPC = vec_t'(1) << 12;
    localparam vec_t V_INC  = vec_t'(1) << 11;
    localparam vec_t V_CLR  = vec_t'(1) << 10;
    localparam vec_t V_LDA2 = vec_t'(1) << 9;
    localparam vec_t V_SALU = vec_t'(1) << 8;
    localparam vec_t V_PADD = vec_t'(1) << 6;
    localparam vec_t V_PB   = vec_t'(3) << 6;
    localparam vec_t V_SA2  = vec_t'(1) << 5;
    localparam vec_t V_SIR  = vec_t'(1) << 4;
    localparam vec_t V_SZ   = vec_t'(1) << 3;
    localparam vec_t V_HALT = vec_t'(1) << 2;
    localparam vec_t V_BERR = vec_t'(1) << 1;
    localparam vec_t V_ILL  = vec_t'(1);

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] op_code;
    logic       mem_ready;
    logic       mem_rd, mem_wr, ir_on_adr, pc_on_adr;
    logic       ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, ld_acii;
    logic       source_ac;
    logic [1:0] pass_add;
    logic       sel_acii, sel_ir, sel_zero;
    logic       halted, bus_err, illegal_op;

    vec_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc_n  = 0;

    cpu_controller #(
        .WAIT_LIMIT(LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op_code   (op_code),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ir_on_adr (ir_on_adr),
        .pc_on_adr (pc_on_adr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .clr_pc    (clr_pc),
        .ld_acii   (ld_acii),
        .source_ac (source_ac),
        .pass_add  (pass_add),
        .sel_acii  (sel_acii),
        .sel_ir    (sel_ir),
        .sel_zero  (sel_zero),
        .halted    (halted),
        .bus_err   (bus_err),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        vec_t act;
        vec_t e;
        act = {mem_rd, mem_wr, ir_on_adr, pc_on_adr, ld_ir, ld_ac,
               ld_pc, inc_pc, clr_pc, ld_acii, source_ac, pass_add,
               sel_acii, sel_ir, sel_zero, halted, bus_err, illegal_op};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                fails++;
                $display("FAIL strobes cycle %0d: got %b want %b",
                         cyc_n, act, e);
            end
            cyc_n++;
        end
    end

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return LIMIT;
        if (r == 1) return LIMIT - 1;
        return $urandom_range(0, 3);
    endfunction

    task automatic cyc(input logic [2:0] op, input logic rdy, input vec_t e);
        op_code   = op;
        mem_ready = rdy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(rop(), rbit(), V_CLR);
        cyc(rop(), rbit(), V_CLR);
        rst = 1'b0;
        cyc(rop(), rbit(), V_CLR);
    endtask

    task automatic halt_check(input int n, input bit berr);
        for (int i = 0; i < n; i++)
            cyc(rop(), rbit(), V_HALT | (berr ? V_BERR : vec_t'(0)));
    endtask

    // A memory request: w unanswered cycles, then either completion or timeout.
    task automatic req_phase(input logic [2:0] op, input bit fetch,
                             input int w, input vec_t vw, input vec_t vd,
                             output bit to);
        to = 1'b0;
        for (int i = 0; i < w && i < LIMIT; i++)
            cyc(fetch ? rop() : op, 1'b0, vw);
        if (w >= LIMIT) to = 1'b1;
        else cyc(fetch ? rop() : op, 1'b1, vd);
    endtask

    task automatic instr(input logic [2:0] op, input int fw, input int mw,
                         output bit stop);
        bit to;
        stop = 1'b0;
        req_phase(op, 1'b1, fw, V_RD | V_PCA, V_RD | V_PCA | V_LDIR, to);
        if (to) begin
            halt_check(4, 1'b1);
            stop = 1'b1;
        end else begin
            cyc(op, rbit(), V_INC);
            case (op)
                LDA: req_phase(op, 1'b0, mw, V_IRA | V_RD,
                               V_IRA | V_RD | V_LDAC, to);
                STA: req_phase(op, 1'b0, mw, V_IRA | V_WR,
                               V_IRA | V_WR, to);
                ADDI: cyc(op, rbit(), V_SIR | V_PADD | V_LDAC | V_SALU);
                CLR:  cyc(op, rbit(), V_SZ | V_PB | V_LDAC | V_SALU);
                JMP: begin
                    cyc(op, rbit(), V_SIR | V_PB | V_LDA2);
                    cyc(op, rbit(), V_LDPC);
                end
                HLT: begin
                    halt_check(4, 1'b0);
                    stop = 1'b1;
                end
`ifdef CTRL_ACII_EN
                MVA:  cyc(op, rbit(), V_LDA2);
                ADDA: cyc(op, rbit(), V_SA2 | V_PADD | V_LDAC | V_SALU);
`else
                MVA, ADDA: cyc(op, rbit(), V_ILL);
`endif
                default: ;
            endcase
            if (to) begin
                halt_check(4, 1'b1);
                stop = 1'b1;
            end
        end
    endtask

    initial begin
        bit stop;
        logic [2:0] op;
        rst       = 1'b0;
        op_code   = 3'd0;
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        instr(ADDI, 0, 0, stop);
        instr(LDA, 0, 4, stop);
        instr(JMP, 0, 0, stop);
        instr(CLR, 1, 0, stop);
        instr(STA, 0, LIMIT - 1, stop);
        instr(ADDA, 0, 0, stop);
        instr(MVA, 2, 0, stop);
        instr(STA, 0, LIMIT, stop);
        do_reset();
        instr(LDA, LIMIT, 0, stop);
        do_reset();

        // abort a memory wait with reset
        cyc(rop(), 1'b1, V_RD | V_PCA | V_LDIR);
        cyc(LDA, rbit(), V_INC);
        cyc(LDA, 1'b0, V_IRA | V_RD);
        cyc(LDA, 1'b0, V_IRA | V_RD);
        do_reset();

        instr(HLT, 0, 0, stop);
        do_reset();

        for (int k = 0; k < 80; k++) begin
            op = rop();
            if (op == HLT && $urandom_range(0, 3) != 0) op = ADDI;
            instr(op, pick_wait(), pick_wait(), stop);
            if (stop) do_reset();
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
